// File: rtl/clock_enable_gen_if.sv
// Increment-register write bus for clock_enable_gen.
// The master side drives single-cycle writes; the slave applies them.
interface clock_enable_gen_if #(
  parameter int unsigned AccWidth = 32
) ();
  logic                inc_wr_en;
  logic [3:0]          inc_wr_chan;
  logic [AccWidth-1:0] inc_wr_data;

  modport master (
    output inc_wr_en,
    output inc_wr_chan,
    output inc_wr_data
  );

  modport slave (
    input inc_wr_en,
    input inc_wr_chan,
    input inc_wr_data
  );
endinterface

// File: rtl/clock_enable_gen.sv
// PLL-lock reset sequencer plus NUM_CHANNELS fractional clock-enable generators
// built from phase accumulators, all in the sys_clk domain.
module clock_enable_gen #(
  parameter int unsigned                     NumChannels = 4,
  parameter int unsigned                     AccWidth    = 32,
  parameter int unsigned                     LockCycles  = 1024,
  parameter logic [NumChannels*AccWidth-1:0] IncInit     = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   pll_locked_i,
  clock_enable_gen_if.slave      wr_if,
  output logic                   sys_reset_o,
  output logic                   running_o,
  output logic [NumChannels-1:0] clk_en_o
);

  localparam int unsigned CntW = $clog2(LockCycles);

  typedef enum logic [1:0] {StWaitLock, StStabilise, StRun} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                sync1_q, lock_s_q;
  logic                sys_reset_q, sys_reset_d;
  logic                running_q, running_d;

  logic [AccWidth-1:0]    acc_q [NumChannels];
  logic [AccWidth-1:0]    acc_d [NumChannels];
  logic [AccWidth-1:0]    inc_q [NumChannels];
  logic [AccWidth-1:0]    inc_d [NumChannels];
  logic [NumChannels-1:0] clk_en_q, clk_en_d;
  logic [AccWidth:0]      sum;

  // State register, synchroniser and registered output decodes
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      sys_reset_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= pll_locked_i;
      lock_s_q    <= sync1_q;
      sys_reset_q <= sys_reset_d;
      running_q   <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s_q) state_d = StStabilise;
      end
      StStabilise: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
        end else if (cnt_q == CntW'(LockCycles - 1)) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s_q) state_d = StWaitLock;
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Decoding the next state lets the outputs switch on the same edge as state_q
  always_comb begin
    sys_reset_d = (state_d != StRun);
    running_d   = (state_d == StRun);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(NumChannels); i++) begin
      sum = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      if (state_q == StRun) begin
        acc_d[i]    = sum[AccWidth-1:0];
        clk_en_d[i] = sum[AccWidth];
      end else begin
        acc_d[i]    = '0;
        clk_en_d[i] = 1'b0;
      end
      // Out-of-range channel indices match no entry and are dropped
      inc_d[i] = (wr_if.inc_wr_en && (wr_if.inc_wr_chan == 4'(i))) ? wr_if.inc_wr_data
                                                                    : inc_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_en_q <= '0;
      for (int i = 0; i < int'(NumChannels); i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= IncInit[i*AccWidth +: AccWidth];
      end
    end else begin
      clk_en_q <= clk_en_d;
      for (int i = 0; i < int'(NumChannels); i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  assign sys_reset_o = sys_reset_q;
  assign running_o   = running_q;
  assign clk_en_o    = clk_en_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomised and directed bench for clock_enable_gen against a cycle-level
// model built from lock-history counting and integer phase arithmetic.
module tb_clock_enable_gen;

  localparam int unsigned NCH      = 4;
  localparam int unsigned AW       = 8;
  localparam int unsigned LC       = 16;
  localparam logic [31:0] INC_INIT = 32'hFF00_8040;  // ch3..ch0 = 255,0,128,64
  localparam int          MODULUS  = 1 << AW;

  logic           clk = 1'b0;
  logic           reset;
  logic           pll_locked;
  logic           sys_reset;
  logic           running;
  logic [NCH-1:0] clk_en;

  int errors = 0;
  int checks = 0;

  // Model: lock_s is pll_locked delayed by two edges; RUN once lock_s has been
  // high for LC+1 consecutive cycles; phases add inc and pulse on overflow.
  int             m_acc [NCH];
  int             m_inc [NCH];
  logic [NCH-1:0] m_en;
  bit             m_s1, m_ls, m_run;
  int             m_ls_run;

  clock_enable_gen_if #(.AccWidth(AW)) wr_if ();

  clock_enable_gen #(
    .NumChannels(NCH),
    .AccWidth   (AW),
    .LockCycles (LC),
    .IncInit    (INC_INIT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .pll_locked_i(pll_locked),
    .wr_if       (wr_if),
    .sys_reset_o (sys_reset),
    .running_o   (running),
    .clk_en_o    (clk_en)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic rst, input logic pl, input logic wen,
                            input logic [3:0] chan, input logic [7:0] data);
    bit next_run;
    int s;
    if (rst) begin
      m_s1 = 0; m_ls = 0; m_ls_run = 0; m_run = 0; m_en = '0;
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0;
        m_inc[i] = int'((INC_INIT >> (i * AW)) & 32'hFF);
      end
    end else begin
      next_run = (m_ls_run >= LC + 1);
      for (int i = 0; i < NCH; i++) begin
        if (m_run) begin
          s        = m_acc[i] + m_inc[i];
          m_en[i]  = (s >= MODULUS);
          m_acc[i] = s % MODULUS;
        end else begin
          m_acc[i] = 0;
          m_en[i]  = 1'b0;
        end
        if (wen && chan == 4'(i)) m_inc[i] = int'(data);
      end
      m_ls     = m_s1;
      m_s1     = pl;
      m_ls_run = m_ls ? m_ls_run + 1 : 0;
      m_run    = next_run;
    end
  endtask

  task automatic step(input logic rst, input logic pl, input logic wen,
                      input logic [3:0] chan, input logic [7:0] data);
    reset             = rst;
    pll_locked        = pl;
    wr_if.inc_wr_en   = wen;
    wr_if.inc_wr_chan = chan;
    wr_if.inc_wr_data = data;
    @(posedge clk);
    model_edge(rst, pl, wen, chan, data);
    @(negedge clk);
  endtask

  // Steps with lock held until running rises; n = steps taken, or -1 on timeout
  task automatic lock_up(output int n);
    n = -1;
    for (int c = 1; c <= 60; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      if (running === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 4'd0, 8'h11);  // reset must beat this write
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (sys_reset !== 1'b1 || running !== 1'b0 || clk_en !== 4'b0000) begin
        errors++;
        $display("FAIL reset: got rst/run/en=%b/%b/%b, want 1/0/0000", sys_reset, running, clk_en);
      end
      step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    end
  endtask

  task automatic test_lock_seq();
    int fall = -1;
    for (int c = 1; c <= 25; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL lock_seq c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
      if (fall < 0 && sys_reset === 1'b0) fall = c;
    end
    checks++;
    if (fall != 19) begin
      errors++;
      $display("FAIL lock_seq_latency: got %0d, want 19", fall);
    end
  endtask

  task automatic test_lock_glitch();
    int fall = -1;
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int c = 0; c < 13; c++) begin
      step(1'b0, (c < 10), 1'b0, 4'd0, 8'd0);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL glitch c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
    end
    for (int c = 1; c <= 40; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL glitch_relock c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
      if (sys_reset === 1'b0) begin
        fall = c;
        break;
      end
    end
    checks++;
    if (fall != 19) begin
      errors++;
      $display("FAIL glitch_latency: got %0d, want 19", fall);
    end
  endtask

  task automatic test_rates();
    int n;
    int cnt [NCH];
    int want [NCH] = '{256, 512, 0, 1020};
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    lock_up(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL rates_lock: got timeout, want running");
    end
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int c = 0; c < 1024; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL rates c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
      for (int i = 0; i < NCH; i++) cnt[i] += int'(clk_en[i]);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (cnt[i] != want[i]) begin
        errors++;
        $display("FAIL rate_count ch%0d: got %0d, want %0d", i, cnt[i], want[i]);
      end
    end
  endtask

  task automatic test_runtime_write();
    int gap = -1;
    int gap2 = -1;
    // Wait for a ch0 pulse so its phase is known to be zero
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      if (clk_en[0] === 1'b1) break;
    end
    step(1'b0, 1'b1, 1'b1, 4'd0, 8'd224);  // phase -> 0x40, inc -> 224
    step(1'b0, 1'b1, 1'b1, 4'd0, 8'd32);   // phase -> 0x20 (with carry), inc -> 32
    checks++;
    if (clk_en[0] !== 1'b1 || clk_en !== m_en) begin
      errors++;
      $display("FAIL wr_carry: got en=%b, want %b with ch0 high", clk_en, m_en);
    end
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL wr_run c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
      if (clk_en[0] === 1'b1) begin
        if (gap < 0) gap = c;
        else if (gap2 < 0) gap2 = c - gap;
      end
    end
    checks++;
    if (gap != 7) begin
      errors++;
      $display("FAIL wr_first_gap: got %0d, want 7", gap);
    end
    checks++;
    if (gap2 != 8) begin
      errors++;
      $display("FAIL wr_period: got %0d, want 8", gap2);
    end
  endtask

  task automatic test_invalid_chan();
    int ch2 = 0;
    step(1'b0, 1'b1, 1'b1, 4'd5, 8'hFF);
    for (int c = 0; c < 64; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL bad_chan c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
      ch2 += int'(clk_en[2]);
    end
    checks++;
    if (ch2 != 0) begin
      errors++;
      $display("FAIL bad_chan_ch2: got %0d pulses, want 0", ch2);
    end
  endtask

  task automatic test_loss_of_lock();
    int n;
    int ch1 = 0;
    step(1'b0, 1'b0, 1'b1, 4'd1, 8'h40);  // write lands while lock drops
    for (int c = 2; c <= 6; c++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL lol c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
      if (c == 4) begin
        checks++;
        if (sys_reset !== 1'b1 || clk_en !== 4'b0000) begin
          errors++;
          $display("FAIL lol_deadline: got rst/en=%b/%b, want 1/0000", sys_reset, clk_en);
        end
      end
    end
    step(1'b1, 1'b0, 1'b1, 4'd1, 8'h77);
    lock_up(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL lol_relock: got timeout, want running");
    end
    for (int c = 0; c < 256; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL lol_init c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
      ch1 += int'(clk_en[1]);
    end
    checks++;
    if (ch1 != 128) begin
      errors++;
      $display("FAIL lol_init_ch1: got %0d pulses, want 128", ch1);
    end
  endtask

  task automatic test_random();
    logic       rst, pl, wen;
    logic [3:0] chan;
    logic [7:0] data;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      pl   = ($urandom_range(0, 99) != 0);
      wen  = ($urandom_range(0, 7) == 0);
      chan = 4'($urandom_range(0, 7));
      data = 8'($urandom);
      step(rst, pl, wen, chan, data);
      checks++;
      if ({sys_reset, running, clk_en} !== {~m_run, m_run, m_en}) begin
        errors++;
        $display("FAIL random c%0d: got rst/run/en=%b/%b/%b, want %b/%b/%b",
                 c, sys_reset, running, clk_en, ~m_run, m_run, m_en);
      end
    end
  endtask

  initial begin
    reset             = 1'b1;
    pll_locked        = 1'b0;
    wr_if.inc_wr_en   = 1'b0;
    wr_if.inc_wr_chan = 4'd0;
    wr_if.inc_wr_data = 8'd0;
    @(negedge clk);
    test_reset();
    test_lock_seq();
    test_lock_glitch();
    test_rates();
    test_runtime_write();
    test_invalid_chan();
    test_loss_of_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
- Parametrised successor to the fixed-output system PLL wrapper.
- Runs entirely in the sys_clk domain. Produces NUM_CHANNELS fractional clock-enable pulse trains using phase accumulators, replacing dedicated PLL outputs for slow clocks such as the PIT and UART baud.
- Also sequences the system reset from the PLL locked flag: synchronise the flag, require a stable-lock window, then release.
- Sits directly after the PLL; drives the CPU/peripheral reset and per-peripheral enables.

Parameters:
- NUM_CHANNELS, 4, number of independent enable outputs (1..16).
- ACC_WIDTH, 32, phase accumulator and increment width in bits (8..32).
- LOCK_CYCLES, 1024, consecutive synchronised-lock cycles required before leaving reset (≥2).
- INC_INIT, {NUM_CHANNELS*ACC_WIDTH{1'b0}}, flat vector of reset increments; channel i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].

Ports:
- clk  in  1  system clock (PLL sys_clk output).
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  asynchronous PLL locked flag.
- inc_wr_en  in  1  single-cycle write strobe for an increment register.
- inc_wr_chan  in  4  channel index for the write.
- inc_wr_data  in  ACC_WIDTH  new increment value.
- sys_reset  out  1  active-high reset to the rest of the system.
- running  out  1  high while in the RUN state.
- clk_en  out  NUM_CHANNELS  per-channel one-cycle enable pulses.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Effect of reset:
  - state = WAIT_LOCK; sync flops = 0; lock counter = 0.
  - all accumulators = 0; increments = INC_INIT.
  - sys_reset = 1, running = 0, clk_en = 0.
- pll_locked synchroniser: two flops, giving lock_s. lock_s lags pll_locked by 2 cycles.
- State machine (registered):
  - WAIT_LOCK: lock counter held at 0. lock_s=1 -> STABILISE.
  - STABILISE: counter increments each cycle while lock_s=1. lock_s=0 -> WAIT_LOCK and counter cleared. Counter == LOCK_CYCLES-1 with lock_s=1 -> RUN.
  - RUN: lock_s=0 -> WAIT_LOCK. The loss-of-lock path has priority over everything else.
- Outputs are registered decodes of state:
  - sys_reset = (state != RUN); running = (state == RUN).
  - sys_reset therefore falls exactly LOCK_CYCLES+1 cycles after lock_s first rises (uninterrupted lock).
  - sys_reset rises on the cycle after RUN is left.
- Accumulators:
  - Outside RUN: acc[i] held at 0 and clk_en[i] = 0.
  - In RUN, every cycle: {carry, acc[i]} <= acc[i] + inc[i], using ACC_WIDTH+1 bits; acc wraps modulo 2^ACC_WIDTH.
  - clk_en[i] is the registered carry: a one-cycle pulse.
  - The first pulse can appear no earlier than the 2nd cycle after running rises.
  - Average pulse rate = f_clk * inc / 2^ACC_WIDTH.
- Increment boundary cases:
  - inc = 0: no pulses.
  - inc = 2^(ACC_WIDTH-1): pulse every 2nd cycle.
  - inc = 2^ACC_WIDTH-1: clk_en low 1 cycle in every 2^ACC_WIDTH.
- Increment writes:
  - inc_wr_en=1 loads inc[inc_wr_chan] at the clock edge. The new value is used in the add on the following cycle.
  - acc is not cleared, so the phase is continuous.
  - inc_wr_chan >= NUM_CHANNELS: write ignored.
  - Writes are accepted in every state, but reset overrides a same-cycle write.
- Simultaneous events:
  - Loss of lock in the same cycle as a write: the write still lands; accumulators clear.
  - A lock glitch shorter than 1 cycle may be missed by the synchroniser. This is acceptable.
- Reset mid-operation: everything returns to reset values on the next edge. Increments revert to INC_INIT.

Test Plan:
- Lock sequencing (LOCK_CYCLES=16): reset, then raise pll_locked at cycle 0 and hold -> sys_reset falls at cycle 19 (2 sync + 16 + 1), running rises in the same cycle, clk_en stays 0 before that.
- Lock glitch (LOCK_CYCLES=16): pll_locked high 10 cycles, low 3 cycles, then high -> counter restarts; sys_reset falls 19 cycles after the final rise.
- Rate check (ACC_WIDTH=8, INC_INIT chans {64,128,0,255}):
  - ch0 pulses every 4 cycles; ch1 every 2 cycles; ch2 never.
  - ch3 pulses in 255 of every 256 cycles.
  - Count over 1024 RUN cycles = 256 / 512 / 0 / 1020.
- Runtime write (ACC_WIDTH=8): in RUN, ch0 inc 64 -> 32 with acc[0]=0x20 -> next pulse after exactly 7 further cycles; later period 8; no acc reset observed.
- Invalid channel: inc_wr_chan=5 with NUM_CHANNELS=4 and data 0xFF -> all clk_en patterns unchanged.
- Loss of lock in RUN: drop pll_locked -> sys_reset=1 and clk_en=0 within 4 cycles. Then assert reset -> increments back to INC_INIT.
